// File: rtl/updown_cnt_pkg.sv
// updown_cnt_pkg: shared direction type, stat width and clamp helper for the up/down counter
package updown_cnt_pkg;
  typedef enum logic {CNT_DOWN = 1'b0, CNT_UP = 1'b1} cnt_dir_e;
  localparam int OVF_W = 8;
  function automatic int unsigned sat_clamp(input int unsigned v, input int unsigned lim);
    return (v > lim) ? lim : v;
  endfunction
endpackage

// File: rtl/updown_counter_param.sv
// updown_counter_param: modulo/saturating up/down counter with load, tc and evt; UPDOWN_CNT_OVF_STAT_EN adds an event counter
module updown_counter_param
  import updown_cnt_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MOD_MAX  = 2**WIDTH-1,
  parameter int STEP     = 1,
  parameter int SAT_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef UPDOWN_CNT_OVF_STAT_EN
  input  logic             ovf_clr,
  output logic [OVF_W-1:0] ovf_cnt,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             evt
);
  localparam logic [WIDTH:0] MAX_X  = (WIDTH+1)'(MOD_MAX);
  localparam logic [WIDTH:0] MOD_X  = MAX_X + 1'b1;
  localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);
  localparam logic           SAT    = SAT_MODE != 0;
  cnt_dir_e dir;
  logic [WIDTH:0] cnt_x, sum;
  logic [WIDTH-1:0] count_nxt;
  logic hit, evt_nxt;
  assign dir   = cnt_dir_e'(up_down);
  assign cnt_x = {1'b0, count};
  assign tc    = (dir == CNT_UP) ? (cnt_x == MAX_X) : (count == '0);
  // hit flags a wrap or clamp; sum is kept one bit wider so overflow past MOD_MAX is visible
  always_comb begin
    sum = cnt_x + STEP_X;
    hit = (dir == CNT_UP) ? (sum > MAX_X) : (cnt_x < STEP_X);
    count_nxt = rst  ? '0 :
                load ? WIDTH'(sat_clamp(int'(load_val), MOD_MAX)) :
                !en  ? count :
                (dir == CNT_UP) ? WIDTH'(hit ? (SAT ? MAX_X : sum - MOD_X) : sum) :
                                  WIDTH'(hit ? (SAT ? '0 : cnt_x + MOD_X - STEP_X) : cnt_x - STEP_X);
    evt_nxt = !rst && !load && en && hit;
  end
  always_ff @(posedge clk) begin
    count <= count_nxt;
    evt   <= evt_nxt;
  end
`ifdef UPDOWN_CNT_OVF_STAT_EN
  always_ff @(posedge clk)
    if (rst || ovf_clr) ovf_cnt <= '0;
    else if (evt_nxt) ovf_cnt <= OVF_W'(sat_clamp(32'(ovf_cnt) + 32'd1, 2**OVF_W-1));
`endif
endmodule

// File: tb/tb_updown_counter_param.sv
// tb_updown_counter_param: directed checks of wrap, saturate and step-3 counters; ovf stats when UPDOWN_CNT_OVF_STAT_EN is set
module tb_updown_counter_param;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, up_down = 1'b1, load = 1'b0, ovf_clr = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] c0, c1, c2;
  logic tc0, tc1, tc2, e0, e1, e2;
  logic [7:0] o0, o1, o2;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  updown_counter_param #(.WIDTH(4), .MOD_MAX(9), .STEP(1), .SAT_MODE(0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .up_down(up_down), .load(load), .load_val(load_val),
`ifdef UPDOWN_CNT_OVF_STAT_EN
    .ovf_clr(ovf_clr), .ovf_cnt(o0),
`endif
    .count(c0), .tc(tc0), .evt(e0));
  updown_counter_param #(.WIDTH(4), .MOD_MAX(9), .STEP(1), .SAT_MODE(1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up_down(up_down), .load(load), .load_val(load_val),
`ifdef UPDOWN_CNT_OVF_STAT_EN
    .ovf_clr(ovf_clr), .ovf_cnt(o1),
`endif
    .count(c1), .tc(tc1), .evt(e1));
  updown_counter_param #(.WIDTH(4), .MOD_MAX(9), .STEP(3), .SAT_MODE(0)) u_step3 (
    .clk(clk), .rst(rst), .en(en), .up_down(up_down), .load(load), .load_val(load_val),
`ifdef UPDOWN_CNT_OVF_STAT_EN
    .ovf_clr(ovf_clr), .ovf_cnt(o2),
`endif
    .count(c2), .tc(tc2), .evt(e2));
`ifndef UPDOWN_CNT_OVF_STAT_EN
  assign o0 = '0;
  assign o1 = '0;
  assign o2 = '0;
`endif
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  initial begin
    tick;
    tick;
    chk("rst_count", c0, 0);
    chk("rst_evt", e0, 0);
    chk("rst_tc_up", tc0, 0);
    up_down = 1'b0;
    #1;
    chk("rst_tc_down", tc0, 1);
    rst = 1'b0; en = 1'b1; up_down = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick;
      chk("t1_count", c0, i % 10);
      chk("t1_evt", e0, (i == 10) ? 1 : 0);
      chk("t1_tc", tc0, (i % 10 == 9) ? 1 : 0);
    end
    load = 1'b1; load_val = 4'd3; en = 1'b0;
    tick;
    chk("t2_load", c0, 3);
    load = 1'b0; en = 1'b1; up_down = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("t2_count", c0, (i < 3) ? 2 - i : 12 - i);
      chk("t2_evt", e0, (i == 3) ? 1 : 0);
      chk("t2_tc", tc0, (i == 2) ? 1 : 0);
    end
    load = 1'b1; load_val = 4'd8; up_down = 1'b1;
    tick;
    chk("t3_load", c1, 8);
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("t3_sat_count", c1, 9);
      chk("t3_sat_evt", e1, (i > 0) ? 1 : 0);
    end
    up_down = 1'b0;
    tick;
    chk("t3_down_count", c1, 8);
    chk("t3_down_evt", e1, 0);
    load = 1'b1; load_val = 4'd0;
    tick;
    load = 1'b0;
    tick;
    chk("t3_sat0_count", c1, 0);
    chk("t3_sat0_evt", e1, 1);
    load = 1'b1; load_val = 4'd8; up_down = 1'b1;
    tick;
    load = 1'b0;
    tick;
    chk("t4_up_count", c2, 1);
    chk("t4_up_evt", e2, 1);
    up_down = 1'b0;
    tick;
    chk("t4_down_count", c2, 8);
    chk("t4_down_evt", e2, 1);
    load = 1'b1; load_val = 4'd15; en = 1'b0;
    tick;
    chk("t5_clamp", c0, 9);
    chk("t5_load_evt", e2, 0);
    load_val = 4'd4; en = 1'b1; up_down = 1'b1;
    tick;
    chk("t5_load_en", c0, 4);
    chk("t5_load_en_evt", e0, 0);
    load = 1'b0; en = 1'b0;
    tick;
    chk("t5_hold", c0, 4);
    rst = 1'b1; load = 1'b1; load_val = 4'd7; en = 1'b1;
    tick;
    chk("t5_rst_load", c0, 0);
    chk("t5_rst_evt", e0, 0);
    load = 1'b0;
`ifdef UPDOWN_CNT_OVF_STAT_EN
    tick;
    chk("t6_rst_ovf", o0, 0);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) tick;
    chk("t6_three_wraps", o0, 3);
    for (int i = 0; i < 9; i++) tick;
    ovf_clr = 1'b1;
    tick;
    chk("t6_clr_evt", e0, 1);
    chk("t6_clr_wins", o0, 0);
    ovf_clr = 1'b0;
    for (int i = 0; i < 2600; i++) tick;
    chk("t6_ovf_sat", o0, 255);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
